// File: rtl/rca_config_pkg.sv
// Shared types and sizing for the result collector.
package rca_config;
    localparam int XLEN                = 32;
    localparam int MAX_IDS             = 8;
    localparam int ID_W                = $clog2(MAX_IDS);
    localparam int RCA_COLLECTOR_DEPTH = MAX_IDS;
    localparam int CNT_W               = $clog2(RCA_COLLECTOR_DEPTH + 1);

    typedef logic [ID_W-1:0] rca_id_t;

    typedef struct packed {
        rca_id_t         id;
        logic [XLEN-1:0] rd;
    } rca_wb_pair_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/rca_collector_fifo.sv
// Count-based synchronous FIFO; head data is presented combinationally.
module rca_collector_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/rca_result_collector.sv
// Pairs grid-slot results with issued instruction IDs and hands them to writeback.
// Optional performance counters are built when RCA_COLLECTOR_PERF_EN is defined.
module rca_result_collector
    import rca_config::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [ID_W-1:0]  issue_id,
    output logic             issue_ready,
    input  logic             slot_valid,
    input  logic [XLEN-1:0]  slot_data,
    output logic             wb_done,
    output logic [ID_W-1:0]  wb_id,
    output logic [XLEN-1:0]  wb_rd,
    input  logic             wb_ack,
    output logic [CNT_W-1:0] outstanding,
    output logic             overflow_err,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_results
);
    logic [ID_W-1:0]  id_head;
    logic [XLEN-1:0]  res_head;
    logic [CNT_W-1:0] id_count, res_count;
    logic             id_full, id_empty, res_full, res_empty;

    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             wb_done_q, wb_done_d;
    rca_wb_pair_t     wb_pair_q, wb_pair_d;
    logic             err_q, err_d;

    logic issue_fire, retire, pair_fire, slot_accept;

    assign issue_ready = (outstanding_q < CNT_W'(RCA_COLLECTOR_DEPTH));
    assign issue_fire  = issue_valid && issue_ready && !id_full;
    assign retire      = wb_done_q && wb_ack;
    assign pair_fire   = !id_empty && !res_empty && (!wb_done_q || wb_ack);
    // A result is only legal if an issued ID is still waiting for one
    assign slot_accept = slot_valid && !res_full && (res_count < id_count);

    rca_collector_fifo #(.WIDTH(ID_W), .DEPTH(RCA_COLLECTOR_DEPTH)) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (issue_fire),
        .push_data (issue_id),
        .pop       (pair_fire),
        .pop_data  (id_head),
        .count     (id_count),
        .full      (id_full),
        .empty     (id_empty)
    );

    rca_collector_fifo #(.WIDTH(XLEN), .DEPTH(RCA_COLLECTOR_DEPTH)) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (slot_accept),
        .push_data (slot_data),
        .pop       (pair_fire),
        .pop_data  (res_head),
        .count     (res_count),
        .full      (res_full),
        .empty     (res_empty)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        case ({issue_fire, retire})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        wb_done_d = wb_done_q;
        wb_pair_d = wb_pair_q;
        if (pair_fire) begin
            wb_done_d    = 1'b1;
            wb_pair_d.id = id_head;
            wb_pair_d.rd = res_head;
        end else if (retire) begin
            wb_done_d = 1'b0;
        end

        err_d = err_q || (slot_valid && !slot_accept);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_q <= '0;
            wb_done_q     <= 1'b0;
            wb_pair_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            wb_done_q     <= wb_done_d;
            wb_pair_q     <= wb_pair_d;
            err_q         <= err_d;
        end
    end

    assign wb_done      = wb_done_q;
    assign wb_id        = wb_pair_q.id;
    assign wb_rd        = wb_pair_q.rd;
    assign outstanding  = outstanding_q;
    assign overflow_err = err_q;

`ifdef RCA_COLLECTOR_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] results_q, results_d;

    always_comb begin
        stall_d   = (wb_done_q && !wb_ack) ? sat_inc(stall_q) : stall_q;
        results_d = retire ? sat_inc(results_q) : results_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q   <= '0;
            results_q <= '0;
        end else begin
            stall_q   <= stall_d;
            results_q <= results_d;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_results      = results_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_results      = '0;
`endif
endmodule

// File: tb/tb_rca_result_collector.sv
// Scoreboard bench for rca_result_collector: directed scenarios plus random traffic.
module tb_rca_result_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [2:0]  issue_id;
    logic        issue_ready;
    logic        slot_valid;
    logic [31:0] slot_data;
    logic        wb_done;
    logic [2:0]  wb_id;
    logic [31:0] wb_rd;
    logic        wb_ack;
    logic [3:0]  outstanding;
    logic        overflow_err;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_results;

    int tests = 0;
    int fails = 0;

    rca_result_collector dut (
        .clk               (clk),
        .rst               (rst),
        .issue_valid       (issue_valid),
        .issue_id          (issue_id),
        .issue_ready       (issue_ready),
        .slot_valid        (slot_valid),
        .slot_data         (slot_data),
        .wb_done           (wb_done),
        .wb_id             (wb_id),
        .wb_rd             (wb_rd),
        .wb_ack            (wb_ack),
        .outstanding       (outstanding),
        .overflow_err      (overflow_err),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_results      (perf_results)
    );

    always #5 clk = ~clk;

    // Reference model: instructions wait for results in issue order,
    // matched pairs wait for writeback in the same order.
    typedef struct {
        logic [2:0]  id;
        logic [31:0] rd;
        int          stamp;
    } pair_t;

    logic [2:0]  unmatched[$];
    pair_t       exp_q[$];
    int          model_out = 0;
    logic        model_err = 1'b0;
    int          last_ret = -100;
    int          cyc = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_res = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: everything sampled at the negedge is what the DUT sees at the next posedge
    always @(negedge clk) begin
        logic exp_done;
        int   avail;
        logic ready_now;
        cyc++;
        if (!rst) begin
            chk("rst_wb_done", wb_done, 0);
            chk("rst_outstanding", outstanding, 0);
            chk("rst_issue_ready", issue_ready, 1);
            chk("rst_overflow_err", overflow_err, 0);
            chk("rst_wb_id", wb_id, 0);
            chk("rst_wb_rd", wb_rd, 0);
            chk("rst_perf_stall", perf_stall_cycles, 0);
            chk("rst_perf_results", perf_results, 0);
            unmatched.delete();
            exp_q.delete();
            model_out = 0;
            model_err = 1'b0;
            last_ret  = -100;
            m_stall   = 0;
            m_res     = 0;
        end else begin
            exp_done = 1'b0;
            if (exp_q.size() > 0) begin
                avail = exp_q[0].stamp + 2;
                if (last_ret + 1 > avail) avail = last_ret + 1;
                exp_done = (cyc >= avail);
            end
            ready_now = (model_out < 8);
            chk("wb_done", wb_done, exp_done);
            if (exp_done) begin
                chk("wb_id", wb_id, exp_q[0].id);
                chk("wb_rd", wb_rd, exp_q[0].rd);
            end
            chk("outstanding", outstanding, model_out);
            chk("issue_ready", issue_ready, ready_now);
            chk("overflow_err", overflow_err, model_err);
`ifdef RCA_COLLECTOR_PERF_EN
            chk("perf_stall", perf_stall_cycles, m_stall);
            chk("perf_results", perf_results, m_res);
`else
            chk("perf_stall", perf_stall_cycles, 0);
            chk("perf_results", perf_results, 0);
`endif
            if (exp_done && wb_ack) begin
                void'(exp_q.pop_front());
                model_out--;
                last_ret = cyc;
                m_res++;
            end
            if (exp_done && !wb_ack) m_stall++;
            if (slot_valid) begin
                if (unmatched.size() > 0)
                    exp_q.push_back('{unmatched.pop_front(), slot_data, cyc});
                else
                    model_err = 1'b1;
            end
            if (issue_valid && ready_now) begin
                unmatched.push_back(issue_id);
                model_out++;
            end
        end
    end

    task automatic step(input logic iv, input logic [2:0] id, input logic sv,
                        input logic [31:0] d, input logic ack);
        issue_valid = iv;
        issue_id    = id;
        slot_valid  = sv;
        slot_data   = d;
        wb_ack      = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, ack);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (model_out != 0 && n < 200) begin
            if (unmatched.size() > 0) step(0, 0, 1, $urandom, 1);
            else step(0, 0, 0, 0, 1);
            n++;
        end
        if (model_out != 0) chk("drain_timeout", model_out, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        issue_valid = 0; issue_id = 0; slot_valid = 0; slot_data = 0; wb_ack = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(2, 0);

        // Ordering with writeback stall
        step(1, 5, 0, 0, 0);
        step(1, 6, 0, 0, 0);
        step(1, 7, 0, 0, 0);
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        step(0, 0, 1, 32'hC, 0);
        idle(3, 0);
        idle(3, 1);
        drain();
        idle(1, 1);
`ifdef RCA_COLLECTOR_PERF_EN
        chk("perf_stall_t3", perf_stall_cycles, 4);
        chk("perf_results_t3", perf_results, 3);
`endif

        // Single pair, minimum latency
        step(1, 3, 0, 0, 1);
        idle(2, 1);
        step(0, 0, 1, 32'hDEADBEEF, 1);
        idle(4, 1);
        chk("single_outstanding", outstanding, 0);

        // Credits exhausted
        for (int i = 0; i < 8; i++) step(1, 3'(i), 0, 0, 0);
        chk("full_ready", issue_ready, 0);
        chk("full_outstanding", outstanding, 8);
        step(1, 3'd7, 0, 0, 0);
        step(0, 0, 1, 32'h1234, 1);
        idle(3, 1);
        chk("full_ready_after_ack", issue_ready, 1);
        drain();

        // Simultaneous issue and retire
        for (int i = 0; i < 4; i++) step(1, 3'(i + 2), 0, 0, 0);
        step(0, 0, 1, 32'h111, 0);
        step(0, 0, 1, 32'h222, 0);
        idle(2, 0);
        step(1, 3'd1, 0, 0, 1);
        chk("simul_outstanding", outstanding, 4);
        drain();

        // Result with nothing outstanding
        step(0, 0, 1, 32'h55, 1);
        idle(3, 1);
        chk("viol_err", overflow_err, 1);
        chk("viol_done", wb_done, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 2) == 0, 3'($urandom), (unmatched.size() > 0) && ($urandom % 3 != 0),
                 $urandom, ($urandom % 4) != 0);
        end
        drain();

        // Mid-operation reset
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 4, 0, 0, 0);
        step(0, 0, 1, 32'hCAFE, 0);
        n = 0;
        while (!wb_done && n < 20) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        chk("pre_reset_done", wb_done, 1);
        chk("pre_reset_outstanding", outstanding, 3);
        rst = 1'b0;
        #1;
        chk("async_rst_done", wb_done, 0);
        chk("async_rst_outstanding", outstanding, 0);
        chk("async_rst_ready", issue_ready, 1);
        chk("async_rst_err", overflow_err, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(1, 0);

        for (int i = 0; i < 300; i++) begin
            step(($urandom % 3) != 0, 3'($urandom), (unmatched.size() > 0) && ($urandom % 2 == 0),
                 $urandom, ($urandom % 3) != 0);
        end
        drain();
        idle(2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
